// File: rtl/ci_arbiter_if.sv
// Custom-instruction bus bundle: one requester-to-responder link.
// The master drives the request fields; the slave answers with result/done.
interface ci_arbiter_if;
  logic        ciStart;
  logic        ciCke;
  logic [7:0]  ciN;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic [31:0] ciResult;
  logic        ciDone;

  modport master (
    output ciStart, ciCke, ciN, ciValueA, ciValueB,
    input  ciResult, ciDone
  );

  modport slave (
    input  ciStart, ciCke, ciN, ciValueA, ciValueB,
    output ciResult, ciDone
  );
endinterface

// File: rtl/ci_arbiter.sv
// Round-robin arbiter sharing one downstream CI slave between two requesters,
// with a watchdog that aborts a hung slave and returns TIMEOUT_VALUE.
module ci_arbiter #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_VALUE  = 32'hDEADBEEF
) (
  input  logic           systemClock,
  input  logic           reset,
  ci_arbiter_if.slave    m0,
  ci_arbiter_if.slave    m1,
  ci_arbiter_if.master   s,
  output logic           busErrorOut
);

  localparam int            TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t             state_q, state_d;
  logic [1:0]         pend_q, pend_d;
  logic               grant_q, grant_d;
  logic               lastGrant_q, lastGrant_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [31:0]        result_q, result_d;
  logic               busError_q, busError_d;
  logic [1:0][7:0]    slotN_q, slotN_d;
  logic [1:0][31:0]   slotA_q, slotA_d;
  logic [1:0][31:0]   slotB_q, slotB_d;

  always_ff @(posedge systemClock) begin
    if (!reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      timer_q     <= '0;
      result_q    <= '0;
      busError_q  <= 1'b0;
      slotN_q     <= '0;
      slotA_q     <= '0;
      slotB_q     <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      timer_q     <= timer_d;
      result_q    <= result_d;
      busError_q  <= busError_d;
      slotN_q     <= slotN_d;
      slotA_q     <= slotA_d;
      slotB_q     <= slotB_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    timer_d     = timer_q;
    result_d    = result_q;
    busError_d  = 1'b0;
    slotN_d     = slotN_q;
    slotA_d     = slotA_q;
    slotB_d     = slotB_q;
    s.ciStart   = 1'b0;
    s.ciCke     = 1'b0;
    s.ciN       = '0;
    s.ciValueA  = '0;
    s.ciValueB  = '0;
    m0.ciDone   = 1'b0;
    m0.ciResult = '0;
    m1.ciDone   = 1'b0;
    m1.ciResult = '0;

    case (state_q)
      IDLE: begin
        if (pend_q != 2'b00) begin
          grant_d = (pend_q == 2'b11) ? ~lastGrant_q : pend_q[1];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        s.ciStart  = 1'b1;
        s.ciCke    = 1'b1;
        s.ciN      = slotN_q[grant_q];
        s.ciValueA = slotA_q[grant_q];
        s.ciValueB = slotB_q[grant_q];
        timer_d    = '0;
        if (s.ciDone) begin
          result_d = s.ciResult;
          state_d  = RESPOND;
        end else begin
          state_d  = WAIT;
        end
      end
      WAIT: begin
        s.ciCke    = 1'b1;
        s.ciN      = slotN_q[grant_q];
        s.ciValueA = slotA_q[grant_q];
        s.ciValueB = slotB_q[grant_q];
        // A done arriving on the final watchdog cycle still wins.
        if (s.ciDone) begin
          result_d   = s.ciResult;
          state_d    = RESPOND;
        end else if (timer_q == TLAST) begin
          result_d   = TIMEOUT_VALUE;
          busError_d = 1'b1;
          state_d    = RESPOND;
        end else begin
          timer_d    = timer_q + TW'(1);
        end
      end
      RESPOND: begin
        if (grant_q) begin
          m1.ciDone   = 1'b1;
          m1.ciResult = result_q;
        end else begin
          m0.ciDone   = 1'b1;
          m0.ciResult = result_q;
        end
        pend_d[grant_q] = 1'b0;
        lastGrant_d     = grant_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Capture after the FSM so a new start in its own RESPOND cycle re-arms the slot.
    if (m0.ciStart && m0.ciCke && (!pend_q[0] || (state_q == RESPOND && !grant_q))) begin
      pend_d[0]  = 1'b1;
      slotN_d[0] = m0.ciN;
      slotA_d[0] = m0.ciValueA;
      slotB_d[0] = m0.ciValueB;
    end
    if (m1.ciStart && m1.ciCke && (!pend_q[1] || (state_q == RESPOND && grant_q))) begin
      pend_d[1]  = 1'b1;
      slotN_d[1] = m1.ciN;
      slotA_d[1] = m1.ciValueA;
      slotB_d[1] = m1.ciValueB;
    end
  end

  assign busErrorOut = busError_q;

endmodule

// File: tb/tb_ci_arbiter.sv
// Directed bench for ci_arbiter: a behavioural slave plus issue/done scoreboards
// that are filled when requests are driven and drained when the DUT responds.
module tb_ci_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busErrorOut;

  int checks = 0;
  int errors = 0;
  int issueCount = 0;
  int doneCount = 0;
  int busErrCount = 0;

  int   slaveLatency = 0;
  logic slaveForceDone = 1'b0;
  logic slaveBusy = 1'b0;
  int   waitCnt = 0;
  logic [7:0]  capN = '0;
  logic [31:0] capA = '0;
  logic [31:0] capB = '0;

  logic [71:0] issueQ[$];
  logic [32:0] doneQ[$];
  logic [71:0] expIssue;
  logic [32:0] expDone;

  ci_arbiter_if m0If ();
  ci_arbiter_if m1If ();
  ci_arbiter_if sIf ();

  ci_arbiter #(
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_VALUE (32'hDEADBEEF)
  ) dut (
    .systemClock(clk),
    .reset      (reset),
    .m0         (m0If),
    .m1         (m1If),
    .s          (sIf),
    .busErrorOut(busErrorOut)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] slaveFn(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b);
    return (a + b) ^ {24'h0, n} ^ 32'h0000_002F;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mask,
                               input logic [7:0] n0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [7:0] n1, input logic [31:0] a1, input logic [31:0] b1);
    @(negedge clk);
    m0If.ciStart  = mask[0];
    m0If.ciCke    = mask[0];
    m0If.ciN      = n0;
    m0If.ciValueA = a0;
    m0If.ciValueB = b0;
    m1If.ciStart  = mask[1];
    m1If.ciCke    = mask[1];
    m1If.ciN      = n1;
    m1If.ciValueA = a1;
    m1If.ciValueB = b1;
    @(negedge clk);
    m0If.ciStart = 1'b0;
    m0If.ciCke   = 1'b0;
    m1If.ciStart = 1'b0;
    m1If.ciCke   = 1'b0;
  endtask

  task automatic waitDrain(input int bound);
    int n = 0;
    while (doneQ.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drainTimeout", doneQ.size(), 0);
  endtask

  // Behavioural slave: answers slaveLatency cycles after ISSUE, or never when negative.
  always @(negedge clk) begin
    sIf.ciDone   = 1'b0;
    sIf.ciResult = '0;
    if (sIf.ciStart === 1'b1) begin
      slaveBusy = 1'b1;
      waitCnt   = 0;
      capN      = sIf.ciN;
      capA      = sIf.ciValueA;
      capB      = sIf.ciValueB;
    end
    if (slaveBusy && sIf.ciCke === 1'b1) begin
      if (waitCnt == slaveLatency) begin
        sIf.ciDone   = 1'b1;
        sIf.ciResult = slaveFn(capN, capA, capB);
        slaveBusy    = 1'b0;
      end
      waitCnt++;
    end
    if (slaveForceDone) begin
      sIf.ciDone   = 1'b1;
      sIf.ciResult = 32'h1234_5678;
    end
  end

  // Scoreboard consumer for downstream issues and upstream completions.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (sIf.ciStart === 1'b1) begin
        issueCount++;
        checkOutput("issueQueued", issueQ.size() != 0, 1);
        if (issueQ.size() != 0) begin
          expIssue = issueQ.pop_front();
          checkOutput("issueN", {24'h0, sIf.ciN}, {24'h0, expIssue[71:64]});
          checkOutput("issueA", sIf.ciValueA, expIssue[63:32]);
          checkOutput("issueB", sIf.ciValueB, expIssue[31:0]);
        end
      end
      if (m0If.ciDone === 1'b1 || m1If.ciDone === 1'b1) begin
        doneCount++;
        checkOutput("oneDone", m0If.ciDone & m1If.ciDone, 0);
        checkOutput("doneQueued", doneQ.size() != 0, 1);
        if (doneQ.size() != 0) begin
          expDone = doneQ.pop_front();
          checkOutput("doneId", m1If.ciDone, expDone[32]);
          checkOutput("doneResult", expDone[32] ? m1If.ciResult : m0If.ciResult, expDone[31:0]);
        end
      end
      if (m0If.ciDone !== 1'b1) checkOutput("m0ResultZero", m0If.ciResult, 0);
      if (m1If.ciDone !== 1'b1) checkOutput("m1ResultZero", m1If.ciResult, 0);
      if (busErrorOut === 1'b1) busErrCount++;
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL globalTimeout: simulation did not complete");
    $fatal(1, "[TB] global time limit reached");
  end

  initial begin
    int  waitCycles;
    int  donesBefore;
    int  issuesBefore;
    bit  seenDone;

    m0If.ciStart = 0; m0If.ciCke = 0; m0If.ciN = 0; m0If.ciValueA = 0; m0If.ciValueB = 0;
    m1If.ciStart = 0; m1If.ciCke = 0; m1If.ciN = 0; m1If.ciValueA = 0; m1If.ciValueB = 0;
    sIf.ciDone = 0; sIf.ciResult = 0;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstStart", sIf.ciStart, 0);
    checkOutput("rstCke", sIf.ciCke, 0);
    checkOutput("rstSN", {24'h0, sIf.ciN}, 0);
    checkOutput("rstSA", sIf.ciValueA, 0);
    checkOutput("rstSB", sIf.ciValueB, 0);
    checkOutput("rstDone", {m1If.ciDone, m0If.ciDone}, 0);
    checkOutput("rstResult", m0If.ciResult | m1If.ciResult, 0);
    checkOutput("rstBusErr", busErrorOut, 0);
    reset = 1'b1;

    $display("[TB] simultaneous pair after reset: m0 first");
    slaveLatency = 2;
    issueQ.push_back({8'd1, 32'd10, 32'd20});
    issueQ.push_back({8'd2, 32'd30, 32'd40});
    doneQ.push_back({1'b0, slaveFn(8'd1, 32'd10, 32'd20)});
    doneQ.push_back({1'b1, slaveFn(8'd2, 32'd30, 32'd40)});
    applyStimulus(2'b11, 8'd1, 32'd10, 32'd20, 8'd2, 32'd30, 32'd40);
    waitDrain(40);
    repeat (2) @(negedge clk);

    $display("[TB] single m0 request with zero-wait slave");
    slaveLatency = 0;
    issueQ.push_back({8'd42, 32'd0, 32'd0});
    doneQ.push_back({1'b0, 32'd5});
    applyStimulus(2'b01, 8'd42, 32'd0, 32'd0, 8'd0, 32'd0, 32'd0);
    checkOutput("latIdle", sIf.ciStart, 0);
    @(negedge clk);
    checkOutput("latIssue", sIf.ciStart, 1);
    @(negedge clk);
    checkOutput("latDone", m0If.ciDone, 1);
    checkOutput("latResult", m0If.ciResult, 32'd5);
    checkOutput("latM1Idle", m1If.ciDone, 0);
    checkOutput("latSNZero", {24'h0, sIf.ciN}, 0);
    @(negedge clk);
    checkOutput("latDonePulse", m0If.ciDone, 0);
    waitDrain(10);

    $display("[TB] simultaneous pair after m0 service: m1 first");
    slaveLatency = 1;
    issueQ.push_back({8'd5, 32'd7, 32'd9});
    issueQ.push_back({8'd4, 32'd3, 32'd8});
    doneQ.push_back({1'b1, slaveFn(8'd5, 32'd7, 32'd9)});
    doneQ.push_back({1'b0, slaveFn(8'd4, 32'd3, 32'd8)});
    applyStimulus(2'b11, 8'd4, 32'd3, 32'd8, 8'd5, 32'd7, 32'd9);
    waitDrain(40);
    repeat (2) @(negedge clk);

    $display("[TB] watchdog timeout on m1");
    slaveLatency = -1;
    issueQ.push_back({8'd7, 32'd5, 32'd6});
    doneQ.push_back({1'b1, 32'hDEADBEEF});
    applyStimulus(2'b10, 8'd0, 32'd0, 32'd0, 8'd7, 32'd5, 32'd6);
    @(negedge clk);
    checkOutput("toIssue", sIf.ciStart, 1);
    waitCycles = 0;
    seenDone   = 0;
    for (int i = 0; i < 40 && !seenDone; i++) begin
      @(negedge clk);
      if (m1If.ciDone === 1'b1) seenDone = 1;
      else if (sIf.ciCke === 1'b1 && sIf.ciStart !== 1'b1) waitCycles++;
    end
    checkOutput("toSeenDone", seenDone, 1);
    checkOutput("toWaitCycles", waitCycles, 8);
    checkOutput("toBusErr", busErrorOut, 1);
    checkOutput("toResult", m1If.ciResult, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("toBusErrPulse", busErrorOut, 0);
    donesBefore = doneCount;
    @(posedge clk);
    slaveForceDone = 1'b1;
    @(posedge clk);
    slaveForceDone = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("lateNoDone", doneCount, donesBefore);
    checkOutput("toErrCount", busErrCount, 1);

    $display("[TB] second m0 start while pending is dropped");
    slaveLatency = 3;
    issuesBefore = issueCount;
    donesBefore  = doneCount;
    issueQ.push_back({8'd3, 32'd1, 32'd0});
    doneQ.push_back({1'b0, slaveFn(8'd3, 32'd1, 32'd0)});
    applyStimulus(2'b01, 8'd3, 32'd1, 32'd0, 8'd0, 32'd0, 32'd0);
    applyStimulus(2'b01, 8'd4, 32'd0, 32'h0000ABCD, 8'd0, 32'd0, 32'd0);
    waitDrain(40);
    repeat (10) @(negedge clk);
    checkOutput("dropIssues", issueCount - issuesBefore, 1);
    checkOutput("dropDones", doneCount - donesBefore, 1);

    $display("[TB] done on the last watchdog cycle");
    slaveLatency = 8;
    issueQ.push_back({8'd9, 32'd100, 32'd200});
    doneQ.push_back({1'b0, slaveFn(8'd9, 32'd100, 32'd200)});
    applyStimulus(2'b01, 8'd9, 32'd100, 32'd200, 8'd0, 32'd0, 32'd0);
    waitDrain(40);
    repeat (2) @(negedge clk);
    checkOutput("raceNoBusErr", busErrCount, 1);

    $display("[TB] reset during WAIT");
    slaveLatency = -1;
    issueQ.push_back({8'd11, 32'h11, 32'h22});
    applyStimulus(2'b01, 8'd11, 32'h11, 32'h22, 8'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("midWaitCke", sIf.ciCke, 1);
    donesBefore  = doneCount;
    issuesBefore = issueCount;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("rstMidCke", sIf.ciCke, 0);
    checkOutput("rstMidStart", sIf.ciStart, 0);
    checkOutput("rstMidSA", sIf.ciValueA, 0);
    checkOutput("rstMidDone", {m1If.ciDone, m0If.ciDone}, 0);
    repeat (15) @(negedge clk);
    checkOutput("rstNoDone", doneCount - donesBefore, 0);
    checkOutput("rstNoReissue", issueCount - issuesBefore, 0);
    checkOutput("rstNoBusErr", busErrCount, 1);

    slaveLatency = 1;
    issueQ.push_back({8'd12, 32'h55, 32'hAA});
    doneQ.push_back({1'b1, slaveFn(8'd12, 32'h55, 32'hAA)});
    applyStimulus(2'b10, 8'd0, 32'd0, 32'd0, 8'd12, 32'h55, 32'hAA);
    waitDrain(40);
    repeat (2) @(negedge clk);
    checkOutput("issueQEmpty", issueQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
